sel_lane_pipe: RTL and testbench

- Parametrised successor to the two-bit select register.
- Each output bit is independently either a constant or a lane of one of two input buses, chosen by a per-transfer select and compile-time per-bit masks.
- Results pass through a DEPTH-stage valid/ready pipeline with occupancy count.
- Sits between control decode and datapath register banks wherever select-driven mixed constant/data buses are registered.

---
 rtl/sel_lane_pipe.sv | 121 ++++++++++++
 tb/tb_sel_lane_pipe.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sel_lane_pipe.sv
// rtl/sel_lane_pipe.sv - per-bit constant/lane select feeding a DEPTH-stage valid/ready pipeline
// Optional SEL_LANE_PIPE_PARITY_EN adds a registered even-parity output out_par.
module sel_lane_pipe #(
  parameter int              WIDTH      = 2,
  parameter int              DEPTH      = 2,
  parameter logic [WIDTH-1:0] SEL1_MASK  = 2'b10,
  parameter logic [WIDTH-1:0] SEL1_CONST = 2'b00,
  parameter logic [WIDTH-1:0] SEL0_MASK  = 2'b01,
  parameter logic [WIDTH-1:0] SEL0_CONST = 2'b10,
  localparam int             CW         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef SEL_LANE_PIPE_PARITY_EN
  output logic             out_par,
`endif
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] up_data [DEPTH];
  logic [WIDTH-1:0] lane_d;
  logic             accept;
  logic             emit;

  always_comb begin
    if (sel) lane_d = (SEL1_MASK & in_a) | (~SEL1_MASK & SEL1_CONST);
    else     lane_d = (SEL0_MASK & in_b) | (~SEL0_MASK & SEL0_CONST);
  end

  // adv[k] is true when any stage from k to the output is empty or the consumer is ready;
  // written in closed form so the chain has no self-referencing combinational loop.
  always_comb begin
    adv = '0;
    for (int k = 0; k < DEPTH; k++) begin
      adv[k] = out_ready;
      for (int j = k; j < DEPTH; j++) begin
        if (!v[j]) adv[k] = 1'b1;
      end
    end
  end

  always_comb begin
    up_v       = '0;
    up_v[0]    = in_valid;
    up_data[0] = lane_d;
    for (int k = 1; k < DEPTH; k++) begin
      up_v[k]    = v[k-1];
      up_data[k] = data[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) data[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (adv[k]) begin
          v[k]    <= up_v[k];
          data[k] <= up_data[k];
        end
      end
    end
  end

`ifdef SEL_LANE_PIPE_PARITY_EN
  logic [DEPTH-1:0] par;
  logic [DEPTH-1:0] up_par;

  always_comb begin
    up_par    = '0;
    up_par[0] = ^lane_d;
    for (int k = 1; k < DEPTH; k++) up_par[k] = par[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (adv[k]) par[k] <= up_par[k];
      end
    end
  end

  assign out_par = par[DEPTH-1];
`endif

  assign in_ready  = adv[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (accept && !emit) begin
      count <= count + CW'(1);
    end else if (emit && !accept) begin
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && accept && !emit) assert (count != CW'(DEPTH));
  end

endmodule

// File: tb/tb_sel_lane_pipe.sv
// tb/tb_sel_lane_pipe.sv - directed scoreboard bench for sel_lane_pipe (default parameters)
module tb_sel_lane_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       sel;
  logic [1:0] in_a;
  logic [1:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic [1:0] count;
`ifdef SEL_LANE_PIPE_PARITY_EN
  logic       out_par;
`endif

  int compared = 0;
  int mismatched = 0;
  logic [1:0] sb [$];
  int model_count = 0;

  sel_lane_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef SEL_LANE_PIPE_PARITY_EN
    .out_par   (out_par),
`endif
    .count     (count)
  );

  always #5 clk = ~clk;

  // Legacy two-bit map written directly, not from the mask parameters.
  function automatic logic [1:0] legacy(input logic s, input logic [1:0] a, input logic [1:0] b);
    return s ? {a[1], 1'b0} : {1'b1, b[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at negedge: drive, settle, score handshakes, cross posedge, return at next negedge.
  task automatic drive(input logic iv, input logic s, input logic [1:0] a, input logic [1:0] b,
                       input logic ordy);
    logic [1:0] e;
    in_valid  = iv;
    sel       = s;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    #1;
    chk("count", 32'(count), 32'(model_count));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e));
`ifdef SEL_LANE_PIPE_PARITY_EN
        chk("out_par", 32'(out_par), 32'(^e));
`endif
        model_count--;
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(legacy(s, a, b));
      model_count++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 1'b0, 2'b00, 2'b00, ordy);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      idle(1'b1);
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: valid exactly two edges after accept
    drive(1'b1, 1'b1, 2'b11, 2'b00, 1'b1);
    chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
    idle(1'b1);
    chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
    chk("lat_cycle2_data", 32'(out_data), 32'h2);
    drain();

    drive(1'b1, 1'b0, 2'b11, 2'b00, 1'b1);
    drive(1'b1, 1'b0, 2'b10, 2'b01, 1'b1);
    drain();

    // Back-to-back, count holds at 2 in steady state
    drive(1'b1, 1'b1, 2'b10, 2'b11, 1'b1);
    drive(1'b1, 1'b0, 2'b01, 2'b10, 1'b1);
    drive(1'b1, 1'b1, 2'b01, 2'b00, 1'b1);
    chk("b2b_count_steady", 32'(count), 32'd2);
    drive(1'b1, 1'b0, 2'b00, 2'b11, 1'b1);
    chk("b2b_count_steady2", 32'(count), 32'd2);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    idle(1'b1);
    chk("b2b_valid_tail", 32'(out_valid), 32'd1);
    drain();

    // Backpressure
    drive(1'b1, 1'b1, 2'b11, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    in_valid = 1'b1; out_ready = 1'b0; #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd2);
    drive(1'b1, 1'b1, 2'b00, 2'b01, 1'b0);
    chk("stall_data_stable", 32'(out_data), 32'h2);
    chk("stall_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1; out_ready = 1'b1; #1;
    chk("full_ready_with_oready", 32'(in_ready), 32'd1);
    drive(1'b1, 1'b0, 2'b00, 2'b01, 1'b1);
    chk("accept_emit_count", 32'(count), 32'd2);
    drain();

    // Bubble collapse
    drive(1'b1, 1'b1, 2'b10, 2'b00, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b0);
    chk("bubble_count", 32'(count), 32'd1);
    chk("bubble_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0; #1;
    chk("bubble_in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    chk("bubble_fill_count", 32'(count), 32'd2);
    drain();

`ifdef SEL_LANE_PIPE_PARITY_EN
    drive(1'b1, 1'b1, 2'b10, 2'b00, 1'b1);
    idle(1'b1);
    chk("par_sel1", 32'(out_par), 32'd1);
    drive(1'b1, 1'b0, 2'b00, 2'b01, 1'b1);
    idle(1'b1);
    chk("par_sel0", 32'(out_par), 32'd0);
    drain();
`endif

    // Asynchronous reset mid-operation
    drive(1'b1, 1'b1, 2'b11, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    chk("pre_reset_count", 32'(count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    model_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 2'b00, 2'b01, 1'b1);
    chk("post_rst_lat1", 32'(out_valid), 32'd0);
    idle(1'b1);
    chk("post_rst_lat2", 32'(out_valid), 32'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
